hilo_mdu: RTL
=============

Name: hilo_mdu

Overview:
- Parametrised HI/LO multiply-divide unit for the MIPS core, placed in the execute stage beside the ALU.
- Performs signed and unsigned multiply and divide, plus multiply-accumulate (madd/msub variants) and mthi/mtlo.
- Divide is an iterative restoring divider, one quotient bit per cycle. A stall output holds the pipeline while a divide runs.
- Adds cancel (exception flush) and defined divide-by-zero and overflow results.

Parameters:
- WIDTH, 32, operand width; HI, LO and each operand are WIDTH bits, product is 2*WIDTH bits.

Ports:
- clk  in  1  system clock, rising edge.
- reset  in  1  asynchronous, active-high; clears all state.
- op_valid  in  1  op presented this cycle.
- op  in  4  operation code (see package).
- cancel  in  1  aborts an in-flight divide.
- rs_data  in  WIDTH  operand A (dividend / mthi / mtlo source).
- rt_data  in  WIDTH  operand B (divisor).
- prod  out  2*WIDTH  combinational signed product rs*rt, for the three-operand mul instruction.
- stall  out  1  combinational; high means hold the issuing pipeline stage.
- busy  out  1  registered; divide in progress.
- done  out  1  registered; one-cycle pulse after a divide result is written.
- hi  out  WIDTH  HI register.
- lo  out  WIDTH  LO register.

Behaviour:
- Reset (asynchronous): hi=0, lo=0, busy=0, done=0, step counter=0, divider datapath=0.
- Decode of op:
  - 0 nop, 1 mult, 2 multu, 3 div, 4 divu, 5 mthi, 6 mtlo, 7 madd, 8 maddu, 9 msub, 10 msubu.
  - 11-15 behave as nop.
- accept = op_valid && !busy && !(done && is_div(op)).
- stall = op_valid && (busy || (is_div(op) && !done)).
- Single-cycle ops write at the accept edge, with no stall:
  - mult/multu: {hi,lo} <= product (signed/unsigned).
  - madd/maddu: {hi,lo} <= {hi,lo} + product.
  - msub/msubu: {hi,lo} <= {hi,lo} - product.
  - Accumulate arithmetic is modulo 2^(2*WIDTH).
  - mthi: hi <= rs_data. mtlo: lo <= rs_data.
- Divide timing (accept in cycle 0):
  - Operands are latched at the accept edge; for div, absolute values and sign flags are captured.
  - busy=1 in cycles 1..WIDTH, one restoring step per edge.
  - At the end of cycle WIDTH: lo <= quotient, hi <= remainder, busy <= 0, done <= 1.
  - Cycle WIDTH+1: done=1 and stall=0, so the pipeline advances. The same div op still presented is not re-accepted.
  - Total stall is WIDTH+1 cycles.
- Signed fix-up: the quotient is negated if the operand signs differ; the remainder takes the dividend's sign.
- Divisor zero (div and divu): lo = all ones, hi = dividend unmodified.
- Signed MIN / -1: lo = MIN, hi = 0.
- A non-div op presented while busy stalls and is accepted on the done cycle.
- cancel with busy=1: busy <= 0 at the next edge, hi/lo untouched, no done pulse.
- cancel while idle is ignored. cancel has priority over the final step, so hi/lo are unwritten.
- A reset mid-divide is the same as a normal reset: no partial write, done=0.
- hi/lo are read directly (mfhi/mflo). A write is visible the cycle after its edge.

Decomposition:
- Package mdu_pkg: op code localparams (OP_NOP through OP_MSUBU), is_div() and is_mul() functions.
- Sub-module mdu_div_iter holds the divider datapath: counter, partial remainder, quotient shift register, and sign fix-up.
  - Interface: start, signed_mode, a, b, cancel → busy, done, q, r.
- Top level holds hi/lo, decode, the accumulate adder, and stall/accept logic.

Test Plan:
- multu rs=0xFFFFFFFF, rt=2 → next cycle hi=0x00000001, lo=0xFFFFFFFE; stall never high.
- mult 3*4, then madd rs=0xFFFFFFFF, rt=1 on the following cycle → hi=0, lo=0x0000000B.
- div rs=0xFFFFFFF9 (-7), rt=2 held with op_valid → stall high for 33 cycles; busy cycles 1..32; done in cycle 33; lo=0xFFFFFFFD, hi=0xFFFFFFFF.
- divu rs=100, rt=0 → lo=0xFFFFFFFF, hi=0x00000064. div 0x80000000 / 0xFFFFFFFF → lo=0x80000000, hi=0.
- div started, cancel pulsed in cycle 10 → busy=0 in cycle 11; hi/lo keep prior values; no done pulse; a new mtlo rs=5 in cycle 11 → lo=5.
- div in progress, reset asserted asynchronously in cycle 7 → hi=lo=0, busy=done=0 immediately; no write after reset release.

Source files
------------

// File: rtl/mdu_pkg.sv
// Shared definitions for the HI/LO multiply-divide unit: op codes, divider
// state encoding and small decode helpers.
package mdu_pkg;

  localparam logic [3:0] OP_NOP   = 4'd0;
  localparam logic [3:0] OP_MULT  = 4'd1;
  localparam logic [3:0] OP_MULTU = 4'd2;
  localparam logic [3:0] OP_DIV   = 4'd3;
  localparam logic [3:0] OP_DIVU  = 4'd4;
  localparam logic [3:0] OP_MTHI  = 4'd5;
  localparam logic [3:0] OP_MTLO  = 4'd6;
  localparam logic [3:0] OP_MADD  = 4'd7;
  localparam logic [3:0] OP_MADDU = 4'd8;
  localparam logic [3:0] OP_MSUB  = 4'd9;
  localparam logic [3:0] OP_MSUBU = 4'd10;

  typedef enum logic {
    DIV_IDLE = 1'b0,
    DIV_RUN  = 1'b1
  } div_state_e;

  function automatic logic is_div(input logic [3:0] op);
    return (op == OP_DIV) || (op == OP_DIVU);
  endfunction

  function automatic logic is_mul(input logic [3:0] op);
    return (op == OP_MULT) || (op == OP_MULTU) || (op == OP_MADD) ||
           (op == OP_MADDU) || (op == OP_MSUB) || (op == OP_MSUBU);
  endfunction

  // Ops that treat their operands as two's complement.
  function automatic logic signed_op(input logic [3:0] op);
    return (op == OP_MULT) || (op == OP_MADD) || (op == OP_MSUB) || (op == OP_DIV);
  endfunction

endpackage

// File: rtl/mdu_div_iter.sv
// Iterative restoring divider, one quotient bit per cycle on magnitudes,
// with sign fix-up and defined divide-by-zero result on the final step.
module mdu_div_iter
  import mdu_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic             signed_mode,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cancel,
  output div_state_e       state_o,
  output logic             done,
  output logic             fin,
  output logic [WIDTH-1:0] q,
  output logic [WIDTH-1:0] r
);

  localparam int CW = $clog2(WIDTH);
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  div_state_e       state_q, state_d;
  logic [CW-1:0]    cnt_q;
  logic [WIDTH-1:0] a_q, b_q, q_q, r_q;
  logic             neg_q_q, neg_r_q, dz_q, done_q;

  logic [WIDTH-1:0] a_abs, b_abs;
  logic [WIDTH:0]   shifted, diff;
  logic             ge;
  logic [WIDTH-1:0] r_step, q_step;

  assign a_abs = (signed_mode && a[WIDTH-1]) ? -a : a;
  assign b_abs = (signed_mode && b[WIDTH-1]) ? -b : b;

  // q_q starts as the dividend magnitude and shifts its bits into the
  // partial remainder while quotient bits fill in from the bottom.
  assign shifted = {r_q, q_q[WIDTH-1]};
  assign diff    = shifted - {1'b0, b_q};
  assign ge      = shifted >= {1'b0, b_q};
  assign r_step  = ge ? diff[WIDTH-1:0] : shifted[WIDTH-1:0];
  assign q_step  = {q_q[WIDTH-2:0], ge};

  assign q = dz_q ? '1  : (neg_q_q ? -q_step : q_step);
  assign r = dz_q ? a_q : (neg_r_q ? -r_step : r_step);

  assign state_o = state_q;
  assign done    = done_q;

  // cancel outranks the final step so an aborted divide never writes back.
  always_comb begin
    state_d = state_q;
    fin     = 1'b0;
    case (state_q)
      DIV_IDLE: begin
        if (start) state_d = DIV_RUN;
      end
      DIV_RUN: begin
        if (cancel) begin
          state_d = DIV_IDLE;
        end else if (cnt_q == LAST) begin
          fin     = 1'b1;
          state_d = DIV_IDLE;
        end
      end
      default: state_d = DIV_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= DIV_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt_q   <= '0;
      a_q     <= '0;
      b_q     <= '0;
      q_q     <= '0;
      r_q     <= '0;
      neg_q_q <= 1'b0;
      neg_r_q <= 1'b0;
      dz_q    <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      done_q <= fin;
      if (state_q == DIV_IDLE && start) begin
        cnt_q   <= '0;
        a_q     <= a;
        b_q     <= b_abs;
        q_q     <= a_abs;
        r_q     <= '0;
        neg_q_q <= signed_mode && (a[WIDTH-1] ^ b[WIDTH-1]);
        neg_r_q <= signed_mode && a[WIDTH-1];
        dz_q    <= (b == '0);
      end else if (state_q == DIV_RUN && !cancel) begin
        cnt_q <= cnt_q + CW'(1);
        q_q   <= q_step;
        r_q   <= r_step;
      end
    end
  end

endmodule

// File: rtl/hilo_mdu.sv
// HI/LO multiply-divide unit: decode, single-cycle multiply/accumulate and
// mthi/mtlo, pipeline stall control, and the iterative divider.
module hilo_mdu
  import mdu_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               op_valid,
  input  logic [3:0]         op,
  input  logic               cancel,
  input  logic [WIDTH-1:0]   rs_data,
  input  logic [WIDTH-1:0]   rt_data,
  output logic [2*WIDTH-1:0] prod,
  output logic               stall,
  output logic               busy,
  output logic               done,
  output logic [WIDTH-1:0]   hi,
  output logic [WIDTH-1:0]   lo
);

  logic [WIDTH-1:0]   hi_q, hi_d, lo_q, lo_d;
  logic [2*WIDTH-1:0] acc, sprod, uprod, mprod, mul_res;
  logic               accept, div_start, div_fin;
  div_state_e         div_state;
  logic [WIDTH-1:0]   div_q, div_r;

  assign busy = (div_state == DIV_RUN);

  // Valid/ready: an op is consumed on the edge where op_valid is high and
  // stall is low; a div seen in its own done cycle is the already-retired one.
  assign accept    = op_valid && !busy && !(done && is_div(op));
  assign stall     = op_valid && (busy || (is_div(op) && !done));
  assign div_start = accept && is_div(op);

  assign sprod = {{WIDTH{rs_data[WIDTH-1]}}, rs_data} * {{WIDTH{rt_data[WIDTH-1]}}, rt_data};
  assign uprod = {{WIDTH{1'b0}}, rs_data} * {{WIDTH{1'b0}}, rt_data};
  assign prod  = sprod;
  assign mprod = signed_op(op) ? sprod : uprod;
  assign acc   = {hi_q, lo_q};

  always_comb begin
    mul_res = mprod;
    case (op)
      OP_MADD, OP_MADDU: mul_res = acc + mprod;
      OP_MSUB, OP_MSUBU: mul_res = acc - mprod;
      default:           mul_res = mprod;
    endcase
  end

  always_comb begin
    hi_d = hi_q;
    lo_d = lo_q;
    if (div_fin) begin
      hi_d = div_r;
      lo_d = div_q;
    end else if (accept) begin
      if (is_mul(op)) begin
        {hi_d, lo_d} = mul_res;
      end else if (op == OP_MTHI) begin
        hi_d = rs_data;
      end else if (op == OP_MTLO) begin
        lo_d = rs_data;
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      hi_q <= '0;
      lo_q <= '0;
    end else begin
      hi_q <= hi_d;
      lo_q <= lo_d;
    end
  end

  assign hi = hi_q;
  assign lo = lo_q;

  mdu_div_iter #(
    .WIDTH(WIDTH)
  ) u_div (
    .clk        (clk),
    .reset      (reset),
    .start      (div_start),
    .signed_mode(op == OP_DIV),
    .a          (rs_data),
    .b          (rt_data),
    .cancel     (cancel),
    .state_o    (div_state),
    .done       (done),
    .fin        (div_fin),
    .q          (div_q),
    .r          (div_r)
  );

endmodule
